// File: rtl/axis_step_driver_if.sv
// rtl/axis_step_driver_if.sv - command/status bundle between motion control and one axis step driver
//
// Purpose: groups the per-axis command inputs and step/status outputs.
// Signals:
//   enable, cmd_pos, cmd_neg : motion commands into the driver
//   step, dir                : registered pulse/direction to the motor driver
//   busy, fault              : driver activity and conflicting-command flag
//   position, at_min, at_max : axis position counter and soft-limit flags
// Modports: master = command source, slave = axis_step_driver.

interface axis_step_driver_if;
  logic        enable;
  logic        cmd_pos;
  logic        cmd_neg;
  logic        step;
  logic        dir;
  logic        busy;
  logic [15:0] position;
  logic        at_min;
  logic        at_max;
  logic        fault;

  modport master (
    output enable, cmd_pos, cmd_neg,
    input  step, dir, busy, position, at_min, at_max, fault
  );

  modport slave (
    input  enable, cmd_pos, cmd_neg,
    output step, dir, busy, position, at_min, at_max, fault
  );
endinterface

// File: rtl/axis_step_driver.sv
// rtl/axis_step_driver.sv - stepper step/dir generator with position counter, soft limits and reversal dead time
//
// Purpose: converts positive/negative direction commands into fixed-period
// step pulses, tracks the axis position and keeps it inside [POS_MIN, POS_MAX].
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : axis_step_driver_if.slave (enable/cmd_pos/cmd_neg in;
//          step/dir/busy/position/at_min/at_max/fault out)

module axis_step_driver #(
  parameter int CLK_DIV  = 50000,
  parameter int PULSE_W  = 100,
  parameter int DEADTIME = 25000,
  parameter int POS_MIN  = 0,
  parameter int POS_MAX  = 180,
  parameter int POS_INIT = 15
) (
  input logic               clk,
  input logic               rst,
  axis_step_driver_if.slave bus
);

  // One shared counter times every state, so it is sized for the longest one.
  localparam int CNT_TOP = (CLK_DIV > DEADTIME) ? CLK_DIV : DEADTIME;
  localparam int CW      = $clog2(CNT_TOP);

  localparam logic [CW-1:0] HI_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] LO_LAST = CW'(CLK_DIV - PULSE_W - 1);
  localparam logic [CW-1:0] DT_LAST = CW'(DEADTIME - 1);

  localparam logic [15:0] PMIN  = 16'(POS_MIN);
  localparam logic [15:0] PMAX  = 16'(POS_MAX);
  localparam logic [15:0] PINIT = 16'(POS_INIT);

  typedef enum logic [1:0] {
    IDLE,
    REVERSE,
    STEP_HI,
    STEP_LO
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          step_q, step_nxt;
  logic          dir_q, dir_nxt;
  logic [15:0]   pos_q, pos_nxt;
  logic          fault_q;

  logic at_min, at_max;
  logic req_pos, req_neg;
  logic go_same, go_rev;

  assign at_min = (pos_q == PMIN);
  assign at_max = (pos_q == PMAX);

  // A request must be unambiguous and must not push past the soft limit.
  assign req_pos = bus.enable & bus.cmd_pos & ~bus.cmd_neg & ~at_max;
  assign req_neg = bus.enable & bus.cmd_neg & ~bus.cmd_pos & ~at_min;

  // Relative to the direction currently driven on dir.
  assign go_same = dir_q ? req_pos : req_neg;
  assign go_rev  = dir_q ? req_neg : req_pos;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    step_nxt  = step_q;
    dir_nxt   = dir_q;
    pos_nxt   = pos_q;

    case (state)
      IDLE: begin
        cnt_nxt  = '0;
        step_nxt = 1'b0;
        if (go_same) begin
          state_nxt = STEP_HI;
          step_nxt  = 1'b1;
        end else if (go_rev) begin
          state_nxt = REVERSE;
          dir_nxt   = ~dir_q;
        end
      end

      REVERSE: begin
        // dir already holds the new direction, so go_same tests the new one.
        if (cnt == DT_LAST) begin
          cnt_nxt = '0;
          if (go_same) begin
            state_nxt = STEP_HI;
            step_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      STEP_HI: begin
        if (cnt == HI_LAST) begin
          state_nxt = STEP_LO;
          cnt_nxt   = '0;
          step_nxt  = 1'b0;
          // Limit was checked before the pulse started; the guard only
          // keeps the counter inside range if parameters are inconsistent.
          if (dir_q) begin
            if (pos_q != PMAX) pos_nxt = pos_q + 16'd1;
          end else begin
            if (pos_q != PMIN) pos_nxt = pos_q - 16'd1;
          end
        end
      end

      STEP_LO: begin
        if (cnt == LO_LAST) begin
          cnt_nxt = '0;
          if (go_same) begin
            state_nxt = STEP_HI;
            step_nxt  = 1'b1;
          end else if (go_rev) begin
            state_nxt = REVERSE;
            dir_nxt   = ~dir_q;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        step_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b1;
      pos_q   <= PINIT;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      step_q  <= step_nxt;
      dir_q   <= dir_nxt;
      pos_q   <= pos_nxt;
      fault_q <= bus.cmd_pos & bus.cmd_neg;
    end
  end

  assign bus.step     = step_q;
  assign bus.dir      = dir_q;
  assign bus.busy     = (state != IDLE);
  assign bus.position = pos_q;
  assign bus.at_min   = at_min;
  assign bus.at_max   = at_max;
  assign bus.fault    = fault_q;

endmodule

// File: tb/tb_axis_step_driver.sv
// tb/tb_axis_step_driver.sv - scoreboard bench for axis_step_driver

module tb_axis_step_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int n_cmp = 0;
  int n_bad = 0;

  axis_step_driver_if bus ();

  axis_step_driver #(
    .CLK_DIV (10),
    .PULSE_W (3),
    .DEADTIME(5),
    .POS_MIN (0),
    .POS_MAX (4),
    .POS_INIT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected output snapshot after a given rising edge.
  // v = {step, dir, busy, fault, at_min, at_max, position}
  typedef struct {
    int          cyc;
    string       nm;
    logic [21:0] v;
  } exp_t;

  exp_t exp_q[$];

  task automatic push(input int off, input string nm, input logic st, input logic dr,
                      input logic bz, input logic f, input logic [15:0] p);
    exp_t e;
    e.cyc = cyc + off;
    e.nm  = nm;
    e.v   = {st, dr, bz, f, (p == 16'd0), (p == 16'd4), p};
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset for one edge; the command inputs are held at the given values.
  task automatic do_reset(input logic cp, input logic cn);
    push(1, "reset", 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
    rst         = 1'b1;
    bus.cmd_pos = cp;
    bus.cmd_neg = cn;
    bus.enable  = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: compare DUT outputs against every expectation due this cycle.
  always @(negedge clk) begin
    logic [21:0] act;
    act = {bus.step, bus.dir, bus.busy, bus.fault, bus.at_min, bus.at_max, bus.position};
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (e.cyc != cyc || act !== e.v) begin
        n_bad++;
        $display("FAIL %s @edge %0d: got step=%b dir=%b busy=%b fault=%b at_min=%b at_max=%b pos=%0d, want step=%b dir=%b busy=%b fault=%b at_min=%b at_max=%b pos=%0d",
                 e.nm, e.cyc, act[21], act[20], act[19], act[18], act[17], act[16], act[15:0],
                 e.v[21], e.v[20], e.v[19], e.v[18], e.v[17], e.v[16], e.v[15:0]);
      end
    end
  end

  initial begin
    bus.enable  = 1'b1;
    bus.cmd_pos = 1'b0;
    bus.cmd_neg = 1'b0;
    ticks(2);

    // Steps up from 2 to the upper limit 4 with cmd_pos held through reset, then stops.
    do_reset(1'b1, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      logic        st;
      logic [15:0] p;
      st = (k >= 1 && k <= 3) || (k >= 11 && k <= 13);
      p  = (k < 4) ? 16'd2 : (k < 14) ? 16'd3 : 16'd4;
      push(k, "pos_run", st, 1'b1, (k < 21), 1'b0, p);
    end
    ticks(25);
    bus.cmd_pos = 1'b0;

    // Reversal from dir=1: dead time, then one negative step.
    do_reset(1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      logic        st;
      logic [15:0] p;
      st = (k >= 6 && k <= 8);
      p  = (k < 9) ? 16'd2 : 16'd1;
      push(k, "reverse", st, 1'b0, (k < 16), 1'b0, p);
    end
    ticks(8);
    bus.cmd_neg = 1'b0;
    ticks(8);

    // Both commands high for one cycle while idle.
    bus.cmd_pos = 1'b1;
    bus.cmd_neg = 1'b1;
    push(1, "fault_set", 1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
    push(2, "fault_clr", 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    push(3, "fault_idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    tick();
    bus.cmd_pos = 1'b0;
    bus.cmd_neg = 1'b0;
    ticks(2);

    // Command dropped during the high phase: pulse and low phase complete.
    do_reset(1'b0, 1'b0);
    bus.cmd_pos = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      push(k, "drop_mid", (k <= 3), 1'b1, (k < 11), 1'b0, (k < 4) ? 16'd2 : 16'd3);
    end
    tick();
    bus.cmd_pos = 1'b0;
    ticks(11);

    // Reset in the middle of a pulse: no position update, back to reset state.
    bus.cmd_pos = 1'b1;
    push(1, "rst_pre", 1'b1, 1'b1, 1'b1, 1'b0, 16'd3);
    push(2, "rst_mid", 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
    push(3, "rst_after", 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
    push(4, "rst_after", 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
    tick();
    rst         = 1'b1;
    bus.cmd_pos = 1'b0;
    tick();
    rst = 1'b0;
    ticks(2);

    // enable=0 blocks a reversal request.
    bus.enable  = 1'b0;
    bus.cmd_neg = 1'b1;
    for (int k = 1; k <= 3; k++) push(k, "disabled", 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
    ticks(3);
    bus.enable  = 1'b1;
    bus.cmd_neg = 1'b0;

    // Reverse and run down to the lower limit 0, then stop.
    do_reset(1'b0, 1'b1);
    for (int k = 1; k <= 28; k++) begin
      logic        st;
      logic [15:0] p;
      st = (k >= 6 && k <= 8) || (k >= 16 && k <= 18);
      p  = (k < 9) ? 16'd2 : (k < 19) ? 16'd1 : 16'd0;
      push(k, "neg_run", st, 1'b0, (k < 26), 1'b0, p);
    end
    ticks(28);
    bus.cmd_neg = 1'b0;

    ticks(3);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: %0d expectations never checked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
